pipe_mips32_fwd: RTL and testbench



---
 rtl/mips32_pkg.sv | 86 ++++++++
 rtl/mips32_hazard_unit.sv | 59 +++++
 rtl/pipe_mips32_fwd.sv | 169 ++++++++++++++++
 tb/tb_pipe_mips32_fwd.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes, pipeline register layouts and field helpers
// for the forwarding MIPS32 pipeline.
package mips32_pkg;
  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0a;
  localparam logic [5:0] OP_SUBI  = 6'h0b;
  localparam logic [5:0] OP_SLTI  = 6'h0c;
  localparam logic [5:0] OP_BNEQZ = 6'h0d;
  localparam logic [5:0] OP_BEQZ  = 6'h0e;
  localparam logic [5:0] OP_NOP   = 6'h3e;
  localparam logic [5:0] OP_HLT   = 6'h3f;

  localparam logic [31:0] NOP_INSTR = 32'hF800_0000;

  localparam logic [1:0] FWD_ID    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOPOP, ILLOP} itype_e;

  typedef struct packed {logic [31:0] ir; logic [31:0] npc;} ifid_t;
  typedef struct packed {
    itype_e t; logic [31:0] ir; logic [31:0] npc; logic [31:0] a; logic [31:0] b;
    logic [31:0] imm; logic [4:0] rs; logic [4:0] rt; logic [4:0] dst;
  } idex_t;
  typedef struct packed {itype_e t; logic [4:0] dst; logic [31:0] alu; logic [31:0] b;} exmem_t;
  typedef struct packed {itype_e t; logic [4:0] dst; logic [31:0] alu; logic [31:0] lmd;} memwb_t;

  function automatic logic [5:0]  f_op (input logic [31:0] ir); return ir[31:26]; endfunction
  function automatic logic [4:0]  f_rs (input logic [31:0] ir); return ir[25:21]; endfunction
  function automatic logic [4:0]  f_rt (input logic [31:0] ir); return ir[20:16]; endfunction
  function automatic logic [4:0]  f_rd (input logic [31:0] ir); return ir[15:11]; endfunction
  function automatic logic [31:0] f_imm(input logic [31:0] ir); return {{16{ir[15]}}, ir[15:0]}; endfunction

  function automatic itype_e f_type(input logic [31:0] ir);
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      OP_NOP:                                        return NOPOP;
      default:                                       return ILLOP;
    endcase
  endfunction

  // Destination is 0 for every non-writer, so dst != 0 doubles as the write enable.
  function automatic logic [4:0] f_dst(input logic [31:0] ir);
    case (f_type(ir))
      RR_ALU:       return f_rd(ir);
      RM_ALU, LOAD: return f_rt(ir);
      default:      return 5'd0;
    endcase
  endfunction

  function automatic logic f_uses_rs(input itype_e t);
    return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD) || (t == STORE) || (t == BRANCH);
  endfunction
  function automatic logic f_uses_rt(input itype_e t);
    return (t == RR_ALU) || (t == STORE);
  endfunction

  function automatic idex_t idex_nop();
    idex_t v;
    v = '0; v.t = NOPOP; v.ir = NOP_INSTR;
    return v;
  endfunction
  function automatic exmem_t exmem_nop();
    exmem_t v;
    v = '0; v.t = NOPOP;
    return v;
  endfunction
  function automatic memwb_t memwb_nop();
    memwb_t v;
    v = '0; v.t = NOPOP;
    return v;
  endfunction
endpackage

// File: rtl/mips32_hazard_unit.sv
// Combinational hazard logic: EX operand forward selects, ID stall and branch flush.
module mips32_hazard_unit
  import mips32_pkg::*;
#(
  parameter int FORWARD_EN = 1
) (
  input  itype_e     id_t_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  itype_e     ex_t_i,
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] ex_dst_i,
  input  itype_e     mem_t_i,
  input  logic [4:0] mem_dst_i,
  input  logic [4:0] wb_dst_i,
  input  logic       br_taken_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       stall_o,
  output logic       flush_o
);
  logic use_rs, use_rt, raw_stall;

  function automatic logic dep(input logic [4:0] d, input logic urs, input logic urt,
                               input logic [4:0] rs, input logic [4:0] rt);
    return (d != 5'd0) && ((urs && rs == d) || (urt && rt == d));
  endfunction

  // A load still in EX/MEM has no data yet; the interlock keeps consumers clear of it.
  function automatic logic [1:0] fsel(input logic [4:0] src, input itype_e mt,
                                      input logic [4:0] md, input logic [4:0] wd);
    if (src == 5'd0)                   return FWD_ID;
    else if (md == src && mt != LOAD)  return FWD_EXMEM;
    else if (wd == src)                return FWD_MEMWB;
    else                               return FWD_ID;
  endfunction

  assign use_rs = f_uses_rs(id_t_i);
  assign use_rt = f_uses_rt(id_t_i);

  always_comb begin
    fwd_a_o   = FWD_ID;
    fwd_b_o   = FWD_ID;
    raw_stall = 1'b0;
    if (FORWARD_EN != 0) begin
      fwd_a_o   = fsel(ex_rs_i, mem_t_i, mem_dst_i, wb_dst_i);
      fwd_b_o   = fsel(ex_rt_i, mem_t_i, mem_dst_i, wb_dst_i);
      raw_stall = (ex_t_i == LOAD) && dep(ex_dst_i, use_rs, use_rt, id_rs_i, id_rt_i);
    end else begin
      raw_stall = dep(ex_dst_i,  use_rs, use_rt, id_rs_i, id_rt_i) ||
                  dep(mem_dst_i, use_rs, use_rt, id_rs_i, id_rt_i) ||
                  dep(wb_dst_i,  use_rs, use_rt, id_rs_i, id_rt_i);
    end
  end

  assign flush_o = br_taken_i;
  assign stall_o = raw_stall && !br_taken_i;
endmodule

// File: rtl/pipe_mips32_fwd.sv
// Single-clock 5-stage MIPS32 pipeline with forwarding, load-use interlock, branch
// flush in EX, HLT drain, reset-time program loader and debug/retire observability.
module pipe_mips32_fwd
  import mips32_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int RESET_PC   = 0,
  parameter int FORWARD_EN = 1
) (
  input  logic                         clk1,
  input  logic                         reset,
  input  logic                         prog_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                  prog_wdata,
  input  logic [4:0]                   dbg_raddr,
  output logic [31:0]                  dbg_rdata,
  output logic                         halted,
  output logic [31:0]                  retired,
  output logic                         illegal_op
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   rf  [32];
  logic [AW-1:0] pc_q, pc_inc, br_tgt;
  ifid_t         ifid_q;
  idex_t         idex_q, idex_d;
  exmem_t        exmem_q, exmem_d;
  memwb_t        memwb_q, memwb_d;
  logic          hlt_seen_q, halted_q, illegal_q;
  logic [31:0]   retired_q;

  logic [31:0] wb_val, opa, opb, alu, rs_v, rt_v;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall, flush, taken, fetch_stop;
  itype_e      id_t;
  logic [4:0]  id_rs, id_rt;

  assign pc_inc = pc_q + AW'(1);
  assign wb_val = (memwb_q.t == LOAD) ? memwb_q.lmd : memwb_q.alu;

  // ID: register read with same-cycle WB bypass.
  assign id_t  = f_type(ifid_q.ir);
  assign id_rs = f_rs(ifid_q.ir);
  assign id_rt = f_rt(ifid_q.ir);
  assign rs_v  = (memwb_q.dst != 5'd0 && memwb_q.dst == id_rs) ? wb_val : rf[id_rs];
  assign rt_v  = (memwb_q.dst != 5'd0 && memwb_q.dst == id_rt) ? wb_val : rf[id_rt];
  assign fetch_stop = hlt_seen_q || (id_t == HALT);

  always_comb begin
    idex_d     = '0;
    idex_d.t   = id_t;
    idex_d.ir  = ifid_q.ir;
    idex_d.npc = ifid_q.npc;
    idex_d.a   = rs_v;
    idex_d.b   = rt_v;
    idex_d.imm = f_imm(ifid_q.ir);
    idex_d.rs  = id_rs;
    idex_d.rt  = id_rt;
    idex_d.dst = f_dst(ifid_q.ir);
  end

  mips32_hazard_unit #(.FORWARD_EN(FORWARD_EN)) u_haz (
    .id_t_i(id_t), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_t_i(idex_q.t), .ex_rs_i(idex_q.rs), .ex_rt_i(idex_q.rt), .ex_dst_i(idex_q.dst),
    .mem_t_i(exmem_q.t), .mem_dst_i(exmem_q.dst), .wb_dst_i(memwb_q.dst),
    .br_taken_i(taken), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .flush_o(flush)
  );

  assign opa = (fwd_a == FWD_EXMEM) ? exmem_q.alu : (fwd_a == FWD_MEMWB) ? wb_val : idex_q.a;
  assign opb = (fwd_b == FWD_EXMEM) ? exmem_q.alu : (fwd_b == FWD_MEMWB) ? wb_val : idex_q.b;

  always_comb begin
    alu   = '0;
    taken = 1'b0;
    case (idex_q.t)
      RR_ALU: case (f_op(idex_q.ir))
        OP_ADD:  alu = opa + opb;
        OP_SUB:  alu = opa - opb;
        OP_AND:  alu = opa & opb;
        OP_OR:   alu = opa | opb;
        OP_SLT:  alu = {31'd0, $signed(opa) < $signed(opb)};
        OP_MUL:  alu = opa * opb;
        default: alu = '0;
      endcase
      RM_ALU: case (f_op(idex_q.ir))
        OP_ADDI: alu = opa + idex_q.imm;
        OP_SUBI: alu = opa - idex_q.imm;
        OP_SLTI: alu = {31'd0, $signed(opa) < $signed(idex_q.imm)};
        default: alu = '0;
      endcase
      LOAD, STORE: alu = opa + idex_q.imm;
      BRANCH: begin
        alu   = idex_q.npc + idex_q.imm;
        taken = (f_op(idex_q.ir) == OP_BEQZ) ? (opa == 32'd0) : (opa != 32'd0);
      end
      default: ;
    endcase
  end

  assign br_tgt  = alu[AW-1:0];
  assign exmem_d = '{t: idex_q.t, dst: idex_q.dst, alu: alu, b: opb};
  assign memwb_d = '{t: exmem_q.t, dst: exmem_q.dst, alu: exmem_q.alu,
                     lmd: mem[exmem_q.alu[AW-1:0]]};

  always_ff @(posedge clk1) begin
    if (reset) begin
      pc_q       <= AW'(RESET_PC);
      ifid_q     <= '{ir: NOP_INSTR, npc: 32'd0};
      idex_q     <= idex_nop();
      exmem_q    <= exmem_nop();
      memwb_q    <= memwb_nop();
      hlt_seen_q <= 1'b0;
    end else if (!halted_q) begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      if (flush) begin
        pc_q   <= br_tgt;
        ifid_q <= '{ir: NOP_INSTR, npc: 32'd0};
        idex_q <= idex_nop();
      end else if (stall) begin
        idex_q <= idex_nop();
      end else begin
        idex_q <= idex_d;
        if (fetch_stop) begin
          ifid_q     <= '{ir: NOP_INSTR, npc: 32'd0};
          hlt_seen_q <= 1'b1;
        end else begin
          pc_q   <= pc_inc;
          ifid_q <= '{ir: mem[pc_q], npc: 32'(pc_inc)};
        end
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!halted_q && memwb_q.dst != 5'd0) begin
      rf[memwb_q.dst] <= wb_val;
    end
  end

  // The loader owns memory during reset; stores only land while running.
  always_ff @(posedge clk1) begin
    if (reset) begin
      if (prog_we) mem[prog_addr] <= prog_wdata;
    end else if (!halted_q && exmem_q.t == STORE) begin
      mem[exmem_q.alu[AW-1:0]] <= exmem_q.b;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else if (!halted_q) begin
      if (memwb_q.t != NOPOP) retired_q <= retired_q + 32'd1;
      if (memwb_q.t == HALT)  halted_q  <= 1'b1;
      if (memwb_q.t == ILLOP) illegal_q <= 1'b1;
    end
  end

  assign dbg_rdata  = (dbg_raddr == 5'd0) ? 32'd0 : rf[dbg_raddr];
  assign halted     = halted_q;
  assign retired    = retired_q;
  assign illegal_op = illegal_q;
endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed bench: one forwarding core and one stall-only core run the same programs.
module tb_pipe_mips32_fwd;
  localparam logic [5:0] ADD = 6'h00, SLT = 6'h04, MUL = 6'h05, LW = 6'h08, SW = 6'h09;
  localparam logic [5:0] ADDI = 6'h0a, SUBI = 6'h0b, SLTI = 6'h0c, BNEQZ = 6'h0d, BEQZ = 6'h0e;
  localparam logic [31:0] HLT = 32'hFC00_0000;
  localparam logic [31:0] ILL = 32'h4000_0000;

  logic        clk1 = 1'b0;
  logic        reset, prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_f, dbg_s, retired_f, retired_s;
  logic        halted_f, halted_s, illegal_f, illegal_s;
  int          checks = 0, errors = 0;
  int          hf, hs;

  always #5 clk1 = ~clk1;

  pipe_mips32_fwd #(.MEM_DEPTH(1024), .RESET_PC(0), .FORWARD_EN(1)) u_fwd (
    .clk1(clk1), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_f),
    .halted(halted_f), .retired(retired_f), .illegal_op(illegal_f));

  pipe_mips32_fwd #(.MEM_DEPTH(1024), .RESET_PC(0), .FORWARD_EN(0)) u_stl (
    .clk1(clk1), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_s),
    .halted(halted_s), .retired(retired_s), .illegal_op(illegal_s));

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction
  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    dbg_raddr = 5'(r);
    #1;
    chk({tag, "_fwd"}, dbg_f, exp);
    chk({tag, "_stl"}, dbg_s, exp);
  endtask

  task automatic begin_load();
    @(negedge clk1);
    reset = 1'b1; prog_we = 1'b0;
    @(negedge clk1);
  endtask

  task automatic put(input int addr, input logic [31:0] data);
    prog_addr = 10'(addr); prog_wdata = data; prog_we = 1'b1;
    @(negedge clk1);
    prog_we = 1'b0;
  endtask

  // Releases reset and reports the edge count (from release) at which each core halts.
  task automatic run(output int f, output int s);
    @(negedge clk1);
    reset = 1'b0;
    f = 0; s = 0;
    for (int n = 1; n <= 80 && (f == 0 || s == 0); n++) begin
      @(posedge clk1); #1;
      if (halted_f && f == 0) f = n;
      if (halted_s && s == 0) s = n;
    end
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; dbg_raddr = '0;
    repeat (2) @(negedge clk1);
    chk("rst_halted", {31'd0, halted_f}, 32'd0);
    chk("rst_retired", retired_f, 32'd0);
    chk("rst_illegal", {31'd0, illegal_s}, 32'd0);

    // Forward chain
    put(0, ri(ADDI, 1, 0, 10)); put(1, rr(ADD, 2, 1, 1)); put(2, rr(ADD, 3, 2, 1)); put(3, HLT);
    run(hf, hs);
    chk("chain_halt_edge_fwd", hf, 8);
    chk("chain_halt_edge_stl", hs, 14);
    chk("chain_retired_fwd", retired_f, 4);
    chk("chain_retired_stl", retired_s, 4);
    chk_reg("chain_r2", 2, 20);
    chk_reg("chain_r3", 3, 30);

    // Load-use
    begin_load();
    put(100, 7); put(0, ri(LW, 4, 0, 100)); put(1, rr(ADD, 5, 4, 4)); put(2, HLT);
    run(hf, hs);
    chk("lu_halt_edge_fwd", hf, 8);
    chk("lu_halt_edge_stl", hs, 10);
    chk_reg("lu_r5", 5, 14);

    // Taken branch
    begin_load();
    put(0, ri(ADDI, 1, 0, 0)); put(1, ri(BEQZ, 0, 1, 2)); put(2, ri(ADDI, 6, 0, 1));
    put(3, ri(ADDI, 6, 0, 2)); put(4, ri(ADDI, 7, 0, 3)); put(5, HLT);
    run(hf, hs);
    chk("beq_halt_edge_fwd", hf, 10);
    chk("beq_halt_edge_stl", hs, 13);
    chk("beq_retired_fwd", retired_f, 4);
    chk_reg("beq_r6", 6, 0);
    chk_reg("beq_r7", 7, 3);

    // Not-taken branch
    begin_load();
    put(1, ri(BNEQZ, 0, 1, 2));
    run(hf, hs);
    chk("bne_halt_edge_fwd", hf, 10);
    chk("bne_retired_stl", retired_s, 6);
    chk_reg("bne_r6", 6, 2);
    chk_reg("bne_r7", 7, 3);

    // Signed compare and MUL wrap
    begin_load();
    put(0, ri(SUBI, 1, 0, 1)); put(1, rr(SLT, 2, 1, 0)); put(2, ri(ADDI, 3, 0, 256));
    put(3, rr(MUL, 4, 3, 3)); put(4, rr(MUL, 5, 4, 4)); put(5, ri(SLTI, 6, 1, 0));
    put(6, rr(SLT, 7, 0, 1)); put(7, HLT);
    run(hf, hs);
    chk("alu_halted_fwd", {31'd0, halted_f}, 1);
    chk("alu_halted_stl", {31'd0, halted_s}, 1);
    chk_reg("alu_r1", 1, 32'hFFFF_FFFF);
    chk_reg("alu_r2", 2, 1);
    chk_reg("alu_r4", 4, 32'h0001_0000);
    chk_reg("alu_r5", 5, 0);
    chk_reg("alu_r6", 6, 1);
    chk_reg("alu_r7", 7, 0);
    chk_reg("alu_r0", 0, 0);

    // Undefined opcode
    begin_load();
    chk("ill_cleared", {31'd0, illegal_f}, 0);
    put(0, ri(ADDI, 1, 0, 3)); put(1, ILL); put(2, ri(ADDI, 2, 0, 4)); put(3, HLT);
    run(hf, hs);
    chk("ill_flag_fwd", {31'd0, illegal_f}, 1);
    chk("ill_flag_stl", {31'd0, illegal_s}, 1);
    chk("ill_retired_fwd", retired_f, 4);
    chk_reg("ill_r2", 2, 4);

    // HLT drain: store just before HLT commits, nothing after it runs
    begin_load();
    chk("drain_ill_rst", {31'd0, illegal_s}, 0);
    put(200, 0); put(201, 32'hAA);
    put(0, ri(ADDI, 1, 0, 55)); put(1, ri(SW, 1, 0, 200)); put(2, HLT);
    put(3, ri(ADDI, 8, 0, 9)); put(4, ri(SW, 8, 0, 201));
    run(hf, hs);
    chk("drain_retired_fwd", retired_f, 3);
    chk("drain_retired_stl", retired_s, 3);
    chk_reg("drain_r8", 8, 0);
    prog_addr = 10'd201; prog_wdata = 32'h55; prog_we = 1'b1;
    repeat (2) @(negedge clk1);
    prog_we = 1'b0;
    repeat (5) @(negedge clk1);
    chk("drain_frozen_retired", retired_f, 3);
    chk("drain_frozen_halted", {31'd0, halted_s}, 1);

    begin_load();
    put(0, ri(LW, 2, 0, 200)); put(1, ri(LW, 3, 0, 201)); put(2, HLT);
    run(hf, hs);
    chk_reg("drain_mem200", 2, 55);
    chk_reg("drain_mem201", 3, 32'hAA);

    // Reset while a store is in EX
    begin_load();
    put(210, 32'h33);
    put(0, ri(ADDI, 1, 0, 77)); put(1, ri(ADDI, 2, 0, 1)); put(2, ri(ADDI, 3, 0, 2));
    put(3, ri(ADDI, 4, 0, 3)); put(4, ri(SW, 1, 0, 210)); put(5, HLT);
    @(negedge clk1);
    reset = 1'b0;
    repeat (6) @(posedge clk1);
    #1;
    chk("mid_retired_before", retired_f, 2);
    @(negedge clk1);
    reset = 1'b1;
    @(negedge clk1);
    chk("mid_retired_rst", retired_f, 0);
    chk("mid_halted_rst", {31'd0, halted_s}, 0);
    chk_reg("mid_r1_rst", 1, 0);
    put(0, ri(LW, 5, 0, 210)); put(1, ri(ADDI, 6, 0, 5)); put(2, HLT);
    run(hf, hs);
    chk_reg("mid_mem210", 5, 32'h33);
    chk_reg("mid_r6", 6, 5);
    chk("mid_retired_fwd", retired_f, 3);
    chk("mid_retired_stl", retired_s, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
